// File: rtl/writeback_commit_pkg.sv
// Shared definitions for the writeback stage.
//   - Load funct3 codes (size/sign of a load result).
//   - Register-index width and the per-entry sideband record kept in the FIFO.
//   - rd_onehot(): decodes a register index into a 32-bit one-hot mask.
package writeback_commit_pkg;

  localparam int REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Everything about a pending entry except its XLEN-wide ALU data.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic [2:0]       funct3;
    logic [1:0]       addr_lo;
  } wb_meta_t;

  function automatic logic [31:0] rd_onehot(input logic [REG_W-1:0] rd);
    return 32'(1) << rd;
  endfunction

endpackage

// File: rtl/writeback_commit_load_align.sv
// wb_load_align: selects the addressed byte/half lane of a load response word
// and sign- or zero-extends it according to funct3.
// Ports:
//   rdata      in  XLEN  raw load response word
//   funct3     in  3     load size/sign code
//   addr_lo    in  2     byte offset of the load
//   data       out XLEN  extended load value (0 for an unknown funct3)
//   bad_funct3 out 1     funct3 is not a supported load code
//   misaligned out 1     half/word access not naturally aligned
module wb_load_align
  import writeback_commit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            bad_funct3,
  output logic            misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Half lane uses only addr_lo[1]; a set addr_lo[0] is flagged, not shifted.
  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    data       = '0;
    bad_funct3 = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH: begin
        data       = {{(XLEN-16){half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_lane};
        misaligned = addr_lo[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (addr_lo != 2'b00);
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_commit.sv
// writeback_commit: writeback stage feeding the register-file write port.
// Execute results are queued in order in a DEPTH-entry FIFO; the head retires
// one entry per cycle (loads wait for their in-order memory response).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   ex_valid_i / ex_ready_o  execute handshake (ready is registered)
//   ex_rd_i, ex_data_i       destination register and ALU result
//   ex_is_load_i             entry waits for memory data
//   ex_funct3_i, ex_addr_lo_i load size/sign code and byte offset
//   mem_rvalid_i, mem_rdata_i in-order load response
//   rf_we_o, rf_waddr_o, rf_wdata_o register-file write port
//   busy_o                   per-register pending mask (bit 0 always 0)
//   err_o                    sticky protocol error
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]  ex_data_i,
  input  logic             ex_is_load_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [1:0]       ex_addr_lo_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             rf_we_o,
  output logic [REG_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic [31:0]      busy_o,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ready_q, ready_d;
  logic             rf_we_q, rf_we_d;
  logic [REG_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             err_q, err_d;

  wb_meta_t         meta_mem [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];

  wb_meta_t         head_meta;
  logic [XLEN-1:0]  head_data;
  logic             not_empty, accept, commit, stray_rsp, load_commit;
  logic [XLEN-1:0]  load_data;
  logic             bad_funct3, misaligned;
  logic [31:0]      busy_all;
  logic [PTR_W-1:0] slot_off;

  assign head_meta = meta_mem[head_q];
  assign head_data = data_mem[head_q];
  assign not_empty = (count_q != '0);
  // Ready reflects the registered count, so a full FIFO refuses even when the
  // head retires on the same edge.
  assign accept    = ex_valid_i & ready_q;
  assign commit    = not_empty & (~head_meta.is_load | mem_rvalid_i);
  assign load_commit = commit & head_meta.is_load;
  // A response with no load at the head is dropped and flagged.
  assign stray_rsp = mem_rvalid_i & (~not_empty | ~head_meta.is_load);

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata      (mem_rdata_i),
    .funct3     (head_meta.funct3),
    .addr_lo    (head_meta.addr_lo),
    .data       (load_data),
    .bad_funct3 (bad_funct3),
    .misaligned (misaligned)
  );

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q | stray_rsp;

    if (accept) tail_d = tail_q + 1'b1;

    if (commit) begin
      head_d     = head_q + 1'b1;
      rf_we_d    = (head_meta.rd != '0);
      rf_waddr_d = head_meta.rd;
      rf_wdata_d = head_meta.is_load ? load_data : head_data;
    end

    if (load_commit && (bad_funct3 || misaligned)) err_d = 1'b1;

    case ({accept, commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ready_d = (count_d < (PTR_W+1)'(DEPTH));
  end

  // Mask of destination registers over the occupied slots [head, head+count).
  always_comb begin
    busy_all = '0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_q;
      if ({1'b0, slot_off} < count_q) busy_all = busy_all | rd_onehot(meta_mem[i].rd);
    end
  end

  assign busy_o = {busy_all[31:1], 1'b0};

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the storage array has no reset; a slot is only read while count says
  // it is occupied, so stale contents are harmless and resetting it is waste.
  always_ff @(posedge clk) begin
    if (accept) begin
      meta_mem[tail_q] <= '{rd: ex_rd_i, is_load: ex_is_load_i,
                            funct3: ex_funct3_i, addr_lo: ex_addr_lo_i};
      data_mem[tail_q] <= ex_data_i;
    end
  end

  assign ex_ready_o = ready_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Writeback stage: the write side of the register file that the decode stage reads.
- Accepts execute results through a valid/ready handshake and queues them in order.
- Merges in-order load data from memory, extends loads by size and sign, and retires one entry per cycle onto the register-file write port.
- Exports a per-register pending scoreboard so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, number of pending-entry FIFO slots (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept.
- ex_rd_i  in  5  destination register.
- ex_data_i  in  XLEN  ALU result (ignored for loads).
- ex_is_load_i  in  1  entry is a load awaiting memory data.
- ex_funct3_i  in  3  load size/sign code.
- ex_addr_lo_i  in  2  load byte offset.
- mem_rvalid_i  in  1  load response valid (responses arrive in load order).
- mem_rdata_i  in  XLEN  load response word.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  write index.
- rf_wdata_o  out  XLEN  write data.
- busy_o  out  32  bit n set when a queued entry targets rn; bit 0 always 0.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, active-high):
  - FIFO emptied, count=0.
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0.
  - ex_ready_o=1 once reset deasserts; busy_o=0.
- Accept: on a clk edge with ex_valid_i & ex_ready_o, the entry {rd, data, is_load, funct3, addr_lo} is written at the tail.
- ex_ready_o = (count < DEPTH), registered. A full FIFO never accepts, even if the head commits that same edge.
- Commit condition for the head entry (only if FIFO is non-empty):
  - non-load: commits unconditionally.
  - load: commits only on an edge where mem_rvalid_i=1.
- At most one commit per edge.
- On a commit edge:
  - rf_we_o <= (rd != 0); rf_waddr_o <= rd.
  - rf_wdata_o <= ALU data, or the extended load data.
  - The head is popped.
- On a non-commit edge, rf_we_o <= 0. rf_waddr_o and rf_wdata_o hold their values.
- rd=0: the entry retires normally with no write (rf_we_o stays 0).
- Latency: accepted at edge N → earliest commit at edge N+1 → rf_we_o high for one cycle after edge N+1.
- Accept and commit on the same edge: both take effect and count is unchanged.
- Load extension (funct3), lane selected by addr_lo:
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: half at addr_lo[1], sign-extended.
  - 101 LHU: half at addr_lo[1], zero-extended.
  - 010 LW: full word.
  - Any other funct3: write data 0 and set err_o.
- Misaligned half/word (LH/LHU with addr_lo[0]=1, LW with addr_lo≠0): the lane is still selected as above and err_o is set.
- mem_rvalid_i=1 while the FIFO is empty or the head is non-load: the response is dropped, err_o is set, and no commit happens on behalf of the response. A non-load head still commits normally.
- err_o is sticky until reset.
- busy_o: combinational OR over valid FIFO slots of the one-hot rd, bit 0 masked. A bit drops on the edge its last matching entry commits.
- FIFO pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Reset mid-operation discards all queued entries. Memory must be quiescent across reset; a stray response afterwards sets err_o.

Decomposition:
- Shared include (alongside the opcode mask header):
  - load funct3 codes LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - register-index width 5.
- Sub-module wb_load_align: combinational lane select plus sign/zero extension.
  - Inputs: rdata, funct3, addr_lo.
  - Outputs: data, bad_funct3, misaligned.
- The FIFO is inline in writeback_commit.

Test Plan:
- Reset then ALU op: accept rd=5, data=0x1234 → one cycle later rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234. busy_o[5]=1 until that commit edge.
- Loads with lane extension:
  - LB, addr_lo=3, mem_rdata=0x80FF_0000 → write 0xFFFF_FF80.
  - LHU, addr_lo=2 → 0x0000_80FF.
  - LW → 0x80FF_0000.
- Ordering stall: load to r3 then ALU to r4, memory response delayed 5 cycles → no write for 5 cycles, then r3 followed by r4 on consecutive cycles. busy_o[3] and busy_o[4] stay high until their respective commits.
- Full FIFO: hold mem_rvalid_i=0 with a load at the head and push DEPTH entries → ex_ready_o=0. One response → head commits and ex_ready_o returns to 1 on the next cycle.
- ALU entry with rd=0, data=0xDEAD → retires with rf_we_o=0. busy_o[0] never set.
- Errors: stray mem_rvalid_i with empty FIFO, or funct3=011 → err_o=1 and held. Asserting reset asynchronously mid-stream clears err_o, rf_we_o, busy_o and count immediately.
